// File: rtl/scheduler2_pkg.sv
// Shared constants and types for the second-generation scheduler commit stage.
package scheduler2_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_END    = 2'd2;
    localparam logic [1:0] ST_EXCEPT = 2'd3;

    localparam int FLAGS_PREG_W = 4;
    localparam int DEST_PREG_W  = 6;
    localparam int DEST_LREG_W  = 5;
    localparam int PC_STRIDE    = 4;

    typedef struct packed {
        logic                    make_flags;
        logic                    writeback;
        logic                    dest_sysreg;
        logic                    ex_branch;
        logic [FLAGS_PREG_W-1:0] flags_preg;
        logic [DEST_PREG_W-1:0]  dest_preg;
        logic [DEST_LREG_W-1:0]  dest_lreg;
    } entry_info_t;
endpackage

// File: rtl/scheduler2_exend_match.sv
// Matches exec-end reports against one commit tag; reports hit, exception and
// the code of the lowest-index excepting port.
module scheduler2_exend_match #(
    parameter int EXEND_CH = 4,
    parameter int TAG_W    = 6,
    parameter int EXCODE_W = 4
) (
    input  logic [TAG_W-1:0]          entry_id_i,
    input  logic [EXEND_CH-1:0]       valid_i,
    input  logic [TAG_W*EXEND_CH-1:0] tag_i,
    input  logic [EXEND_CH-1:0]       except_i,
    input  logic [EXCODE_W*EXEND_CH-1:0] excode_i,
    output logic                      hit_o,
    output logic                      except_o,
    output logic [EXCODE_W-1:0]       excode_o
);
    logic [EXEND_CH-1:0] hit;

    genvar j;
    generate
        for (j = 0; j < EXEND_CH; j++) begin : g_port
            assign hit[j] = valid_i[j] && (tag_i[j*TAG_W +: TAG_W] == entry_id_i);
        end
    endgenerate

    // Scan high to low so the lowest excepting port is written last.
    always_comb begin
        excode_o = '0;
        for (int p = EXEND_CH - 1; p >= 0; p--) begin
            if (hit[p] && except_i[p]) excode_o = excode_i[p*EXCODE_W +: EXCODE_W];
        end
    end

    assign hit_o    = |hit;
    assign except_o = |(hit & except_i);
endmodule

// File: rtl/scheduler2_commit_entry.sv
// One reorder-buffer slot: captures a dispatched instruction, tracks its
// completion/exception and presents it to in-order commit.
module scheduler2_commit_entry
    import scheduler2_pkg::*;
#(
    parameter int ENTRY_ID  = 0,
    parameter int TAG_W     = 6,
    parameter int REGIST_CH = 2,
    parameter int EXEND_CH  = 4,
    parameter int PC_W      = 32,
    parameter int EXCODE_W  = 4
) (
    input  logic                              iCLOCK,
    input  logic                              iRESET,
    input  logic                              iLOCK,
    input  logic                              iRESTART_VALID,
    input  logic [TAG_W-1:0]                  iREGIST_POINTER,
    input  logic [REGIST_CH-1:0]              iREGIST_VALID,
    input  logic [REGIST_CH-1:0]              iREGIST_MAKE_FLAGS,
    input  logic [REGIST_CH-1:0]              iREGIST_WRITEBACK,
    input  logic [REGIST_CH-1:0]              iREGIST_DEST_SYSREG,
    input  logic [REGIST_CH-1:0]              iREGIST_EX_BRANCH,
    input  logic [FLAGS_PREG_W*REGIST_CH-1:0] iREGIST_FLAGS_PREG_POINTER,
    input  logic [DEST_PREG_W*REGIST_CH-1:0]  iREGIST_DEST_PREG_POINTER,
    input  logic [DEST_LREG_W*REGIST_CH-1:0]  iREGIST_DEST_LREG_POINTER,
    input  logic [PC_W-1:0]                   iREGIST_PC,
    input  logic                              iCOMMIT_VALID,
    input  logic [EXEND_CH-1:0]               iEXEND_VALID,
    input  logic [TAG_W*EXEND_CH-1:0]         iEXEND_COMMIT_TAG,
    input  logic [EXEND_CH-1:0]               iEXEND_EXCEPT,
    input  logic [EXCODE_W*EXEND_CH-1:0]      iEXEND_EXCODE,
    output logic                              oINFO_VALID,
    output logic                              oINFO_EX_END,
    output logic                              oINFO_EXCEPT,
    output logic [EXCODE_W-1:0]               oINFO_EXCODE,
    output logic                              oINFO_MAKE_FLAGS_VALID,
    output logic                              oINFO_WRITEBACK_VALID,
    output logic                              oINFO_DEST_SYSREG,
    output logic                              oINFO_EX_BRANCH,
    output logic [PC_W-1:0]                   oINFO_PC,
    output logic [FLAGS_PREG_W-1:0]           oINFO_FLAGS_PREG_POINTER,
    output logic [DEST_PREG_W-1:0]            oINFO_DEST_PREG_POINTER,
    output logic [DEST_LREG_W-1:0]            oINFO_DEST_LREG_POINTER,
    output logic                              oINFO_FREE
);
    localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(ENTRY_ID);

    logic [1:0]          state_q, state_d;
    entry_info_t         info_q, info_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [EXCODE_W-1:0] excode_q, excode_d;

    logic [REGIST_CH-1:0] reg_match;
    logic                 reg_hit;
    entry_info_t          reg_info;
    logic [PC_W-1:0]      reg_pc;

    logic                 ex_hit, ex_except;
    logic [EXCODE_W-1:0]  ex_code;

    genvar k;
    generate
        for (k = 0; k < REGIST_CH; k++) begin : g_slot
            assign reg_match[k] = iREGIST_VALID[k] &&
                                  (MY_TAG == TAG_W'(iREGIST_POINTER + TAG_W'(k)));
        end
    endgenerate

    always_comb begin
        reg_hit  = 1'b0;
        reg_info = '0;
        reg_pc   = '0;
        for (int s = REGIST_CH - 1; s >= 0; s--) begin
            if (reg_match[s]) begin
                reg_hit              = 1'b1;
                reg_info.make_flags  = iREGIST_MAKE_FLAGS[s];
                reg_info.writeback   = iREGIST_WRITEBACK[s];
                reg_info.dest_sysreg = iREGIST_DEST_SYSREG[s];
                reg_info.ex_branch   = iREGIST_EX_BRANCH[s];
                reg_info.flags_preg  = iREGIST_FLAGS_PREG_POINTER[s*FLAGS_PREG_W +: FLAGS_PREG_W];
                reg_info.dest_preg   = iREGIST_DEST_PREG_POINTER[s*DEST_PREG_W +: DEST_PREG_W];
                reg_info.dest_lreg   = iREGIST_DEST_LREG_POINTER[s*DEST_LREG_W +: DEST_LREG_W];
                reg_pc               = iREGIST_PC + PC_W'(PC_STRIDE * s);
            end
        end
    end

    scheduler2_exend_match #(
        .EXEND_CH (EXEND_CH),
        .TAG_W    (TAG_W),
        .EXCODE_W (EXCODE_W)
    ) u_exend_match (
        .entry_id_i (MY_TAG),
        .valid_i    (iEXEND_VALID),
        .tag_i      (iEXEND_COMMIT_TAG),
        .except_i   (iEXEND_EXCEPT),
        .excode_i   (iEXEND_EXCODE),
        .hit_o      (ex_hit),
        .except_o   (ex_except),
        .excode_o   (ex_code)
    );

    always_comb begin
        state_d  = state_q;
        info_d   = info_q;
        pc_d     = pc_q;
        excode_d = excode_q;
        if (iRESTART_VALID) begin
            state_d  = ST_IDLE;
            info_d   = '0;
            pc_d     = '0;
            excode_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!iLOCK && reg_hit) begin
                        state_d  = ST_WAIT;
                        info_d   = reg_info;
                        pc_d     = reg_pc;
                        excode_d = '0;
                    end
                end
                ST_WAIT: begin
                    if (ex_hit) begin
                        state_d = ex_except ? ST_EXCEPT : ST_END;
                        if (ex_except) excode_d = ex_code;
                    end
                end
                ST_END, ST_EXCEPT: begin
                    // PC and EX_BRANCH stay visible until the slot is reused.
                    if (iCOMMIT_VALID) begin
                        state_d          = ST_IDLE;
                        info_d           = '0;
                        info_d.ex_branch = info_q.ex_branch;
                        excode_d         = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q  <= ST_IDLE;
            info_q   <= '0;
            pc_q     <= '0;
            excode_q <= '0;
        end else begin
            state_q  <= state_d;
            info_q   <= info_d;
            pc_q     <= pc_d;
            excode_q <= excode_d;
        end
    end

    assign oINFO_VALID              = (state_q != ST_IDLE);
    assign oINFO_EX_END             = (state_q == ST_END) || (state_q == ST_EXCEPT);
    assign oINFO_EXCEPT             = (state_q == ST_EXCEPT);
    assign oINFO_EXCODE             = excode_q;
    assign oINFO_MAKE_FLAGS_VALID   = info_q.make_flags;
    assign oINFO_WRITEBACK_VALID    = info_q.writeback;
    assign oINFO_DEST_SYSREG        = info_q.dest_sysreg;
    assign oINFO_EX_BRANCH          = info_q.ex_branch;
    assign oINFO_PC                 = pc_q;
    assign oINFO_FLAGS_PREG_POINTER = info_q.flags_preg;
    assign oINFO_DEST_PREG_POINTER  = info_q.dest_preg;
    assign oINFO_DEST_LREG_POINTER  = info_q.dest_lreg;
    assign oINFO_FREE               = iRESTART_VALID && (state_q != ST_IDLE);
endmodule

// File: tb/tb_scheduler2_commit_entry.sv
// Bench for scheduler2_commit_entry: two slots (tags 5 and 0) on shared inputs,
// directed vector table, hand sequences and randomized reference-model checks.
module tb_scheduler2_commit_entry;
    logic        clk, rst, lock, restart, commit;
    logic [5:0]  ptr;
    logic [1:0]  rv, mf, wb, sys, br;
    logic [7:0]  fp;
    logic [11:0] dp;
    logic [9:0]  dl;
    logic [31:0] pc;
    logic [7:0]  exv, exx;
    logic [47:0] extag;
    logic [31:0] excd;

    logic        a_valid, a_end, a_exc, a_mf, a_wb, a_sys, a_br, a_free;
    logic [3:0]  a_code, a_fp;
    logic [5:0]  a_dp;
    logic [4:0]  a_dl;
    logic [31:0] a_pc;
    logic        b_valid, b_end, b_exc, b_mf, b_wb, b_sys, b_br, b_free;
    logic [3:0]  b_code, b_fp;
    logic [5:0]  b_dp;
    logic [4:0]  b_dl;
    logic [31:0] b_pc;

    scheduler2_commit_entry #(.ENTRY_ID(5), .TAG_W(6), .REGIST_CH(2), .EXEND_CH(8),
                              .PC_W(32), .EXCODE_W(4)) dut_a (
        .iCLOCK(clk), .iRESET(rst), .iLOCK(lock), .iRESTART_VALID(restart),
        .iREGIST_POINTER(ptr), .iREGIST_VALID(rv), .iREGIST_MAKE_FLAGS(mf),
        .iREGIST_WRITEBACK(wb), .iREGIST_DEST_SYSREG(sys), .iREGIST_EX_BRANCH(br),
        .iREGIST_FLAGS_PREG_POINTER(fp), .iREGIST_DEST_PREG_POINTER(dp),
        .iREGIST_DEST_LREG_POINTER(dl), .iREGIST_PC(pc), .iCOMMIT_VALID(commit),
        .iEXEND_VALID(exv), .iEXEND_COMMIT_TAG(extag), .iEXEND_EXCEPT(exx),
        .iEXEND_EXCODE(excd),
        .oINFO_VALID(a_valid), .oINFO_EX_END(a_end), .oINFO_EXCEPT(a_exc),
        .oINFO_EXCODE(a_code), .oINFO_MAKE_FLAGS_VALID(a_mf),
        .oINFO_WRITEBACK_VALID(a_wb), .oINFO_DEST_SYSREG(a_sys),
        .oINFO_EX_BRANCH(a_br), .oINFO_PC(a_pc), .oINFO_FLAGS_PREG_POINTER(a_fp),
        .oINFO_DEST_PREG_POINTER(a_dp), .oINFO_DEST_LREG_POINTER(a_dl),
        .oINFO_FREE(a_free)
    );

    scheduler2_commit_entry #(.ENTRY_ID(0), .TAG_W(6), .REGIST_CH(2), .EXEND_CH(8),
                              .PC_W(32), .EXCODE_W(4)) dut_b (
        .iCLOCK(clk), .iRESET(rst), .iLOCK(lock), .iRESTART_VALID(restart),
        .iREGIST_POINTER(ptr), .iREGIST_VALID(rv), .iREGIST_MAKE_FLAGS(mf),
        .iREGIST_WRITEBACK(wb), .iREGIST_DEST_SYSREG(sys), .iREGIST_EX_BRANCH(br),
        .iREGIST_FLAGS_PREG_POINTER(fp), .iREGIST_DEST_PREG_POINTER(dp),
        .iREGIST_DEST_LREG_POINTER(dl), .iREGIST_PC(pc), .iCOMMIT_VALID(commit),
        .iEXEND_VALID(exv), .iEXEND_COMMIT_TAG(extag), .iEXEND_EXCEPT(exx),
        .iEXEND_EXCODE(excd),
        .oINFO_VALID(b_valid), .oINFO_EX_END(b_end), .oINFO_EXCEPT(b_exc),
        .oINFO_EXCODE(b_code), .oINFO_MAKE_FLAGS_VALID(b_mf),
        .oINFO_WRITEBACK_VALID(b_wb), .oINFO_DEST_SYSREG(b_sys),
        .oINFO_EX_BRANCH(b_br), .oINFO_PC(b_pc), .oINFO_FLAGS_PREG_POINTER(b_fp),
        .oINFO_DEST_PREG_POINTER(b_dp), .oINFO_DEST_LREG_POINTER(b_dl),
        .oINFO_FREE(b_free)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what the slot holds, in terms of occupied/done/faulted.
    typedef struct packed {
        logic        valid, done, exc;
        logic [3:0]  code;
        logic        mf, wb, sys, br;
        logic [31:0] pc;
        logic [3:0]  fp;
        logic [5:0]  dp;
        logic [4:0]  dl;
    } m_t;

    m_t ma, mb;
    int checks = 0, errors = 0;

    function automatic m_t nxt(input m_t m, input int id);
        m_t r;
        logic hit, ex;
        r = m;
        if (restart) return '0;
        if (!m.valid) begin
            if (!lock) begin
                for (int k = 0; k < 2; k++) begin
                    if (rv[k] && ((int'(ptr) + k) % 64 == id)) begin
                        r.valid = 1'b1; r.done = 1'b0; r.exc = 1'b0; r.code = 4'd0;
                        r.mf = mf[k]; r.wb = wb[k]; r.sys = sys[k]; r.br = br[k];
                        r.fp = fp[k*4 +: 4]; r.dp = dp[k*6 +: 6]; r.dl = dl[k*5 +: 5];
                        r.pc = pc + 32'(4 * k);
                        break;
                    end
                end
            end
        end else if (!m.done) begin
            hit = 1'b0; ex = 1'b0;
            for (int j = 0; j < 8; j++) begin
                if (exv[j] && int'(extag[j*6 +: 6]) == id) begin
                    hit = 1'b1;
                    if (exx[j] && !ex) begin
                        ex = 1'b1;
                        r.code = excd[j*4 +: 4];
                    end
                end
            end
            if (hit) begin
                r.done = 1'b1;
                r.exc  = ex;
            end
        end else if (commit) begin
            r = '0;
            r.pc = m.pc;
            r.br = m.br;
        end
        return r;
    endfunction

    function automatic logic [58:0] mvec(input m_t m);
        return {m.valid, m.done, m.exc, m.code, m.mf, m.wb, m.sys, m.br,
                m.pc, m.fp, m.dp, m.dl, restart && m.valid};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_chk();
        chk("model_a", 64'({a_valid, a_end, a_exc, a_code, a_mf, a_wb, a_sys, a_br,
                            a_pc, a_fp, a_dp, a_dl, a_free}), 64'(mvec(ma)));
        chk("model_b", 64'({b_valid, b_end, b_exc, b_code, b_mf, b_wb, b_sys, b_br,
                            b_pc, b_fp, b_dp, b_dl, b_free}), 64'(mvec(mb)));
    endtask

    // Inputs are already applied; check mid-cycle, take the edge, advance models.
    task automatic step();
        #1;
        model_chk();
        @(posedge clk);
        ma = nxt(ma, 5);
        mb = nxt(mb, 0);
        #1;
    endtask

    task automatic idle_inputs();
        lock = 1'b0; restart = 1'b0; commit = 1'b0; ptr = 6'd0; rv = 2'b00;
        pc = 32'h0; exv = 8'h00; exx = 8'h00; extag = 48'h0; excd = 32'h0;
        mf = 2'b10; wb = 2'b11; sys = 2'b10; br = 2'b10;
        fp = {4'hA, 4'h1}; dp = {6'h2A, 6'h11}; dl = {5'h1A, 5'h01};
    endtask

    typedef struct {
        logic        lk, rs;
        logic [5:0]  ptr;
        logic [1:0]  rv;
        logic [31:0] pc;
        logic        cm;
        logic [7:0]  exv, exx;
        logic [31:0] cd;
        logic [5:0]  tag;
        logic        e_free, e_valid, e_end, e_exc;
        logic [3:0]  e_code;
        logic        e_wb, e_br;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[18];

    initial begin
        idle_inputs();
        rst = 1'b1;
        ma = '0; mb = '0;
        // lk rs ptr rv pc cm exv exx cd tag | free valid end exc code wb br pc (slot tag 5)
        tbl[0]  = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b0,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,32'h0};
        tbl[1]  = '{1'b0,1'b0,6'd4,2'b10,32'h100,1'b0,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b1,1'b0,1'b0,4'd0,1'b1,1'b1,32'h104};
        tbl[2]  = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b1,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b1,1'b0,1'b0,4'd0,1'b1,1'b1,32'h104};
        tbl[3]  = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b0,8'h24,8'h24,32'h0090_0300,6'd5, 1'b0,1'b1,1'b1,1'b1,4'd3,1'b1,1'b1,32'h104};
        tbl[4]  = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b0,8'h02,8'h02,32'h0000_0070,6'd5, 1'b0,1'b1,1'b1,1'b1,4'd3,1'b1,1'b1,32'h104};
        tbl[5]  = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b1,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b1,32'h104};
        tbl[6]  = '{1'b0,1'b0,6'd4,2'b11,32'h200,1'b0,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b1,1'b0,1'b0,4'd0,1'b1,1'b1,32'h204};
        tbl[7]  = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b0,8'h01,8'h00,32'h0,6'd5, 1'b0,1'b1,1'b1,1'b0,4'd0,1'b1,1'b1,32'h204};
        tbl[8]  = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b1,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b1,32'h204};
        tbl[9]  = '{1'b1,1'b0,6'd4,2'b10,32'h300,1'b0,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b1,32'h204};
        tbl[10] = '{1'b0,1'b0,6'd5,2'b01,32'h300,1'b0,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b1,1'b0,1'b0,4'd0,1'b1,1'b0,32'h300};
        tbl[11] = '{1'b0,1'b1,6'd0,2'b00,32'h0,  1'b0,8'h00,8'h00,32'h0,6'd0, 1'b1,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,32'h0};
        tbl[12] = '{1'b0,1'b1,6'd0,2'b00,32'h0,  1'b0,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,32'h0};
        tbl[13] = '{1'b0,1'b1,6'd4,2'b10,32'h400,1'b0,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,32'h0};
        tbl[14] = '{1'b0,1'b0,6'd4,2'b10,32'h400,1'b0,8'h00,8'h00,32'h0,6'd0, 1'b0,1'b1,1'b0,1'b0,4'd0,1'b1,1'b1,32'h404};
        tbl[15] = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b0,8'h08,8'h00,32'h0,6'd7, 1'b0,1'b1,1'b0,1'b0,4'd0,1'b1,1'b1,32'h404};
        tbl[16] = '{1'b0,1'b0,6'd0,2'b00,32'h0,  1'b0,8'h08,8'h00,32'h0,6'd5, 1'b0,1'b1,1'b1,1'b0,4'd0,1'b1,1'b1,32'h404};
        tbl[17] = '{1'b0,1'b1,6'd0,2'b00,32'h0,  1'b1,8'h00,8'h00,32'h0,6'd0, 1'b1,1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,32'h0};

        repeat (2) @(posedge clk);
        #1;
        model_chk();
        chk("reset_outs", 64'({a_valid, a_end, a_exc, a_code, a_pc, a_free}), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            idle_inputs();
            lock = tbl[i].lk; restart = tbl[i].rs; ptr = tbl[i].ptr; rv = tbl[i].rv;
            pc = tbl[i].pc; commit = tbl[i].cm; exv = tbl[i].exv; exx = tbl[i].exx;
            excd = tbl[i].cd; extag = {8{tbl[i].tag}};
            #1;
            chk($sformatf("free_row%0d", i), 64'(a_free), 64'(tbl[i].e_free));
            step();
            chk($sformatf("outs_row%0d", i),
                64'({a_valid, a_end, a_exc, a_code, a_wb, a_br, a_pc}),
                64'({tbl[i].e_valid, tbl[i].e_end, tbl[i].e_exc, tbl[i].e_code,
                     tbl[i].e_wb, tbl[i].e_br, tbl[i].e_pc}));
        end

        // Tag wrap on slot 0: pointer 63, slot 1 -> tag 0; blocked by lock first.
        idle_inputs();
        lock = 1'b1; ptr = 6'd63; rv = 2'b10; pc = 32'h40;
        step();
        chk("wrap_locked_valid", 64'(b_valid), 64'h0);
        lock = 1'b0;
        step();
        chk("wrap_valid_pc", 64'({b_valid, b_pc, b_dp}), 64'({1'b1, 32'h44, 6'h2A}));
        idle_inputs();
        restart = 1'b1;
        step();

        // Asynchronous reset between edges while completed.
        idle_inputs();
        ptr = 6'd4; rv = 2'b10; pc = 32'h500;
        step();
        idle_inputs();
        exv = 8'h01; extag = {8{6'd5}};
        step();
        idle_inputs();
        chk("end_before_reset", 64'({a_valid, a_end}), 64'h3);
        #2;
        rst = 1'b1;
        #1;
        ma = '0; mb = '0;
        chk("async_reset_outs", 64'({a_valid, a_end, a_exc, a_wb, a_br, a_pc}), 64'h0);
        model_chk();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int c = 0; c < 2000; c++) begin
            lock    = ($urandom_range(0, 3) == 0);
            restart = ($urandom_range(0, 15) == 0);
            commit  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: ptr = 6'd63;
                1: ptr = 6'd0;
                2: ptr = 6'd4;
                3: ptr = 6'd5;
                default: ptr = 6'($urandom_range(0, 63));
            endcase
            rv  = 2'($urandom); mf = 2'($urandom); wb = 2'($urandom);
            sys = 2'($urandom); br = 2'($urandom);
            fp  = 8'($urandom); dp = 12'($urandom); dl = 10'($urandom);
            pc  = $urandom;
            exv = 8'($urandom) & 8'($urandom);
            exx = 8'($urandom);
            excd = $urandom;
            for (int j = 0; j < 8; j++) begin
                case ($urandom_range(0, 3))
                    0: extag[j*6 +: 6] = 6'd5;
                    1: extag[j*6 +: 6] = 6'd0;
                    default: extag[j*6 +: 6] = 6'($urandom_range(0, 63));
                endcase
            end
            step();
        end
        #1;
        model_chk();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
